// File: rtl/shared_ram_ctrl_pkg.sv
// shared_ram_ctrl_pkg -- shared constants and encodings for the shared RAM
// controller slice.
//   RAM_DATA_W_DEF / RAM_ADDR_W_DEF : default word and word-address widths
//   state_e                         : controller FSM state (IDLE, TURN)
//   gnt_e                           : per-cycle grant type (NONE, IF, MRD, MWR)
package shared_ram_ctrl_pkg;

  localparam int unsigned RAM_DATA_W_DEF = 16;
  localparam int unsigned RAM_ADDR_W_DEF = 14;

  typedef enum logic {
    ST_IDLE,
    ST_TURN
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_MRD,
    GNT_MWR
  } gnt_e;

endpackage

// File: rtl/shared_ram_ctrl_if.sv
// shared_ram_ctrl_if -- bundles the instruction-fetch port, the data port and
// the stall/parity status of shared_ram_ctrl.
//   master : requester side (drives requests, addresses, write data)
//   slave  : controller side (drives fetched/read data, valids, stall_req)
//   parity_err exists only when RAM_PARITY_EN is defined.
interface shared_ram_ctrl_if
  import shared_ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W_DEF,
  parameter int unsigned ADDR_W = RAM_ADDR_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_inst;
  logic              if_valid;
  logic              mem_ce;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_valid;
  logic              stall_req;
`ifdef RAM_PARITY_EN
  logic              parity_err;
`endif

  modport master (
    output if_req, if_addr, mem_ce, mem_re, mem_we, mem_addr, mem_data_i,
    input  if_inst, if_valid, mem_data_o, mem_valid, stall_req
`ifdef RAM_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  if_req, if_addr, mem_ce, mem_re, mem_we, mem_addr, mem_data_i,
    output if_inst, if_valid, mem_data_o, mem_valid, stall_req
`ifdef RAM_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/shared_ram_ctrl_ram_sp_core.sv
// ram_sp_core -- synchronous single-port RAM, 2**ADDR_W words, no reset on
// the array. One access per enabled cycle: write when we=1, else read; the
// read word is registered and appears on rdata after the edge.
// Optional (RAM_PARITY_EN): each word carries one even-parity bit computed on
// write; rpar_err flags a mismatch of the registered read word.
//   clk, en, we, addr, wdata : access control and write data
//   rdata                    : last read word
//   rpar_err                 : parity mismatch of rdata (RAM_PARITY_EN only)
module ram_sp_core
  import shared_ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W_DEF,
  parameter int unsigned ADDR_W = RAM_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef RAM_PARITY_EN
  output logic              rpar_err,
`endif
  output logic [DATA_W-1:0] rdata
);

`ifdef RAM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rword_q;
  logic [WORD_W-1:0] wword_d;

  always_comb begin
`ifdef RAM_PARITY_EN
    wword_d = {^wdata, wdata};
`else
    wword_d = wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wword_d;
      end else begin
        rword_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rword_q[DATA_W-1:0];
`ifdef RAM_PARITY_EN
  // Even parity: data bits XOR stored bit is zero for an intact word.
  assign rpar_err = ^rword_q;
`endif

endmodule

// File: rtl/shared_ram_ctrl.sv
// shared_ram_ctrl -- arbitrates one single-port RAM between an instruction
// fetch port and a data port. Data accesses win; a fetch that loses raises
// stall_req. Reads return one cycle after the grant with a one-cycle valid.
// WR_TURN=1 inserts one idle (TURN) cycle after every write.
//   clk          : clock
//   rst          : asynchronous active-low reset
//   bus (slave)  : fetch/data ports, valids, stall_req, parity_err
// Optional feature macro: RAM_PARITY_EN (per-word parity and parity_err).
module shared_ram_ctrl
  import shared_ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = RAM_DATA_W_DEF,
  parameter int unsigned ADDR_W  = RAM_ADDR_W_DEF,
  parameter int unsigned WR_TURN = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_ram_ctrl_if.slave     bus
);

  state_e            state_q, state_d;
  gnt_e              gnt;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;
  logic [DATA_W-1:0] mem_hold_q, mem_hold_d;
  logic [DATA_W-1:0] rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;

  always_comb begin
    state_d = state_q;
    gnt     = GNT_NONE;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_ce && bus.mem_we) begin
          gnt = GNT_MWR;
        end else if (bus.mem_ce && bus.mem_re) begin
          gnt = GNT_MRD;
        end else if (bus.if_req) begin
          gnt = GNT_IF;
        end
        if (gnt == GNT_MWR && WR_TURN != 0) begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if_valid_d  = (gnt == GNT_IF);
    mem_valid_d = (gnt == GNT_MRD);
    // The RAM output register is shared; each port keeps its own copy of the
    // last word it received so it can hold while the other port reads.
    if_hold_d   = if_valid_q  ? rdata : if_hold_q;
    mem_hold_d  = mem_valid_q ? rdata : mem_hold_q;

    ram_en   = (gnt != GNT_NONE);
    ram_we   = (gnt == GNT_MWR);
    ram_addr = (gnt == GNT_IF) ? bus.if_addr : bus.mem_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_hold_q   <= '0;
      mem_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      if_hold_q   <= if_hold_d;
      mem_hold_q  <= mem_hold_d;
    end
  end

`ifdef RAM_PARITY_EN
  logic rd_par_err;
`endif

  ram_sp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .en       (ram_en),
    .we       (ram_we),
    .addr     (ram_addr),
    .wdata    (bus.mem_data_i),
`ifdef RAM_PARITY_EN
    .rpar_err (rd_par_err),
`endif
    .rdata    (rdata)
  );

  // Outputs are zero during reset because both valids and holds reset to 0.
  assign bus.if_inst    = if_valid_q  ? rdata : if_hold_q;
  assign bus.mem_data_o = mem_valid_q ? rdata : mem_hold_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.stall_req  = bus.if_req && (gnt != GNT_IF);
`ifdef RAM_PARITY_EN
  assign bus.parity_err = (if_valid_q || mem_valid_q) && rd_par_err;
`endif

endmodule

// File: tb/tb_shared_ram_ctrl.sv
// tb_shared_ram_ctrl -- directed bench for shared_ram_ctrl. Instance u_dut0
// uses WR_TURN=0, u_dut1 uses WR_TURN=1; both share clk and rst.
// Parity checks are built only when RAM_PARITY_EN is defined.
module tb_shared_ram_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 14;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  shared_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  shared_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

  shared_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WR_TURN(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  shared_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WR_TURN(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    b0.if_req = 1'b0; b0.mem_ce = 1'b0; b0.mem_re = 1'b0; b0.mem_we = 1'b0;
  endtask

  task automatic idle1();
    b1.if_req = 1'b0; b1.mem_ce = 1'b0; b1.mem_re = 1'b0; b1.mem_we = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    b0.mem_ce = 1'b1; b0.mem_we = 1'b1; b0.mem_re = 1'b0;
    b0.mem_addr = a; b0.mem_data_i = d;
    step();
    idle0();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle0(); idle1();
    b0.if_addr = '0; b0.mem_addr = '0; b0.mem_data_i = '0;
    b1.if_addr = '0; b1.mem_addr = '0; b1.mem_data_i = '0;

    // Reset state
    #2;
    check("rst_if_inst",   32'(b0.if_inst),    32'h0);
    check("rst_mem_data",  32'(b0.mem_data_o), 32'h0);
    check("rst_if_valid",  32'(b0.if_valid),   32'h0);
    check("rst_mem_valid", 32'(b0.mem_valid),  32'h0);
    step(); step();
    rst = 1'b1;
    step();

    // Write 0x1234 @0x0005, then read it back
    b0.mem_ce = 1'b1; b0.mem_we = 1'b1; b0.mem_addr = 14'h0005; b0.mem_data_i = 16'h1234;
    step();
    b0.mem_we = 1'b0; b0.mem_re = 1'b1;
    check("wr_no_valid", 32'(b0.mem_valid), 32'h0);
    step();
    check("rd_valid", 32'(b0.mem_valid),  32'h1);
    check("rd_data",  32'(b0.mem_data_o), 32'h1234);
    idle0();
    step();
    check("rd_valid_pulse", 32'(b0.mem_valid),  32'h0);
    check("rd_data_hold",   32'(b0.mem_data_o), 32'h1234);

    // Fetch/data conflict
    wr0(14'h0003, 16'hA003);
    wr0(14'h0010, 16'hB010);
    b0.if_req = 1'b1; b0.if_addr = 14'h0003;
    b0.mem_ce = 1'b1; b0.mem_re = 1'b1; b0.mem_addr = 14'h0010;
    #1;
    check("conf_stall", 32'(b0.stall_req), 32'h1);
    step();
    check("conf_mem_valid", 32'(b0.mem_valid),  32'h1);
    check("conf_mem_data",  32'(b0.mem_data_o), 32'hB010);
    check("conf_if_valid",  32'(b0.if_valid),   32'h0);
    b0.mem_ce = 1'b0; b0.mem_re = 1'b0;
    #1;
    check("retry_no_stall", 32'(b0.stall_req), 32'h0);
    step();
    check("retry_if_valid",  32'(b0.if_valid),   32'h1);
    check("retry_if_inst",   32'(b0.if_inst),    32'hA003);
    check("retry_mem_hold",  32'(b0.mem_data_o), 32'hB010);
    idle0();
    step();
    check("if_valid_pulse", 32'(b0.if_valid), 32'h0);
    check("if_inst_hold",   32'(b0.if_inst),  32'hA003);

    // re=we=1 executes as a write only
    b0.mem_ce = 1'b1; b0.mem_we = 1'b1; b0.mem_re = 1'b1;
    b0.mem_addr = 14'h3FFF; b0.mem_data_i = 16'hBEEF;
    step();
    b0.mem_we = 1'b0;
    check("rewe_no_valid", 32'(b0.mem_valid), 32'h0);
    step();
    check("rewe_rd_valid", 32'(b0.mem_valid),  32'h1);
    check("rewe_rd_data",  32'(b0.mem_data_o), 32'hBEEF);
    idle0();
    step();

    // Reset asserted during a read-grant cycle
    b0.mem_ce = 1'b1; b0.mem_re = 1'b1; b0.mem_addr = 14'h0005;
    #2;
    rst = 1'b0;
    #1;
    check("mrst_mem_data",  32'(b0.mem_data_o), 32'h0);
    check("mrst_if_inst",   32'(b0.if_inst),    32'h0);
    check("mrst_mem_valid", 32'(b0.mem_valid),  32'h0);
    check("mrst_if_valid",  32'(b0.if_valid),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle0();
    step();
    check("mrst_no_pulse", 32'(b0.mem_valid),  32'h0);
    check("mrst_data_0",   32'(b0.mem_data_o), 32'h0);
    b0.mem_ce = 1'b1; b0.mem_re = 1'b1; b0.mem_addr = 14'h0005;
    step();
    check("mrst_retained", 32'(b0.mem_data_o), 32'h1234);
    idle0();
    step();

    // WR_TURN=1: write at N with fetch held from N
    b1.mem_ce = 1'b1; b1.mem_we = 1'b1; b1.mem_addr = 14'h0007; b1.mem_data_i = 16'h7777;
    b1.if_req = 1'b1; b1.if_addr = 14'h0007;
    #1;
    check("turn_stall_n", 32'(b1.stall_req), 32'h1);
    step();
    b1.mem_ce = 1'b0; b1.mem_we = 1'b0;
    #1;
    check("turn_stall_n1", 32'(b1.stall_req), 32'h1);
    step();
    check("turn_stall_n2", 32'(b1.stall_req), 32'h0);
    check("turn_if_n2",    32'(b1.if_valid),  32'h0);
    step();
    check("turn_if_valid_n3", 32'(b1.if_valid), 32'h1);
    check("turn_if_inst_n3",  32'(b1.if_inst),  32'h7777);
    idle1();
    step();

    // WR_TURN=1: data read presented during TURN waits for IDLE
    b1.mem_ce = 1'b1; b1.mem_we = 1'b1; b1.mem_addr = 14'h0008; b1.mem_data_i = 16'h8888;
    step();
    b1.mem_we = 1'b0; b1.mem_re = 1'b1;
    step();
    check("turn_rd_blocked", 32'(b1.mem_valid), 32'h0);
    step();
    check("turn_rd_valid", 32'(b1.mem_valid),  32'h1);
    check("turn_rd_data",  32'(b1.mem_data_o), 32'h8888);
    idle1();
    step();

`ifdef RAM_PARITY_EN
    wr0(14'h0001, 16'h00F0);
    b0.if_req = 1'b1; b0.if_addr = 14'h0001;
    step();
    check("par_clean_valid", 32'(b0.if_valid),   32'h1);
    check("par_clean_err",   32'(b0.parity_err), 32'h0);
    idle0();
    step();
    u_dut0.u_ram.mem_q[1] = u_dut0.u_ram.mem_q[1] ^ 17'h00001;
    b0.if_req = 1'b1; b0.if_addr = 14'h0001;
    step();
    check("par_flip_valid", 32'(b0.if_valid),   32'h1);
    check("par_flip_err",   32'(b0.parity_err), 32'h1);
    idle0();
    step();
    check("par_err_pulse",  32'(b0.parity_err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_ram_ctrl.md
SHARED_RAM_CTRL -- requirements
Module: shared_ram_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the word width of the instruction port, the data port and the storage.
REQ-002 Parameter ADDR_W, default 14, SHALL set the word-address width; storage depth SHALL be 2**ADDR_W words.
REQ-003 Parameter WR_TURN, default 0 (legal values 0 and 1), SHALL insert WR_TURN idle cycles after every write.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  instruction fetch request.
REQ-007 if_addr  in  ADDR_W  fetch word address (pc).
REQ-008 if_inst  out  DATA_W  fetched instruction.
REQ-009 if_valid  out  1  high when if_inst holds the word for the fetch granted in the previous cycle.
REQ-010 mem_ce  in  1  data port chip enable (high = enabled).
REQ-011 mem_re / mem_we  in  1 each  data read / write enable.
REQ-012 mem_addr  in  ADDR_W  data word address.
REQ-013 mem_data_i  in  DATA_W  write data.
REQ-014 mem_data_o  out  DATA_W  read data.
REQ-015 mem_valid  out  1  high when mem_data_o holds the word for the read granted in the previous cycle.
REQ-016 stall_req  out  1  combinational; high in any cycle in which if_req is high and no fetch is granted.
REQ-017 parity_err  out  1  present only when RAM_PARITY_EN is defined.

Function
REQ-018 Single-port storage: at most one access (fetch, data read or data write) SHALL be granted per cycle.
REQ-019 A data access is requested when mem_ce=1 and (mem_re=1 or mem_we=1). It SHALL win arbitration over a fetch.
REQ-020 mem_we=1 together with mem_re=1 SHALL be executed as a write only; mem_valid SHALL be 0 in the next cycle.
REQ-021 Writes SHALL commit mem_data_i to mem_addr at the granting edge; writes produce no valid pulse.
REQ-022 Read latency SHALL be exactly 1 cycle: the granted word appears on if_inst or mem_data_o together with its valid strobe in the following cycle.
REQ-023 A read that follows a write to the same address SHALL return the new data.
REQ-024 if_inst and mem_data_o SHALL hold their last value when no read is granted; the valid strobes are single-cycle pulses.
REQ-025 FSM states:
- IDLE: grant per REQ-019.
- TURN: entered after a write when WR_TURN=1; no grant; stall_req=if_req.
- The FSM SHALL return to IDLE after one cycle in TURN.
- With WR_TURN=0 the FSM SHALL never leave IDLE.
REQ-026 A data request arriving during TURN SHALL NOT be granted; it is granted in the next IDLE cycle if still asserted (the requester holds it).
REQ-027 Address inputs are exactly ADDR_W bits; there is no wrap or truncation logic.

Reset
REQ-028 While rst=0, all of the following SHALL be forced asynchronously: if_inst=0, mem_data_o=0, if_valid=0, mem_valid=0, parity_err=0, FSM=IDLE.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 A read granted in the cycle rst asserts SHALL produce no valid pulse after release.

Configuration
REQ-031 RAM_PARITY_EN defined:
- Each word SHALL store one extra even-parity bit computed on write.
- parity_err SHALL pulse together with if_valid or mem_valid whenever the returned word's stored parity mismatches.
REQ-032 RAM_PARITY_EN undefined:
- No parity storage SHALL exist.
- The parity_err port SHALL be absent.

Structure
REQ-033 The shared package SHALL hold:
- constants for the default DATA_W and ADDR_W;
- the FSM state encoding (IDLE, TURN);
- the grant-type encoding (NONE, IF, MRD, MWR).
REQ-034 Storage SHALL be one sub-module, ram_sp_core: synchronous single-port RAM with parameters DATA_W and ADDR_W, optional parity bit, and no reset on its array.

Verification
REQ-035 Write then read: write 0x1234 to 0x0005, next cycle read 0x0005 -> mem_valid=1, mem_data_o=0x1234 one cycle after the read grant.
REQ-036 Conflict: if_req=1 at if_addr 0x0003 together with a data read of 0x0010 -> stall_req=1 that cycle; next cycle mem_valid=1 and if_valid=0; the retried fetch then gives if_valid=1.
REQ-037 WR_TURN=1: write at cycle N, fetch held from N -> stall_req=1 in cycles N and N+1; fetch granted at N+2; if_valid=1 at N+3.
REQ-038 re=we=1: write 0xBEEF to 0x3FFF -> mem_valid=0 next cycle; a later read of 0x3FFF returns 0xBEEF.
REQ-039 Reset mid-read: assert rst=0 in the read-grant cycle -> all outputs 0 immediately; no valid pulse after release; stored data is retained.
REQ-040 RAM_PARITY_EN: force-flip one stored bit at 0x0001, then fetch 0x0001 -> parity_err=1 coincident with if_valid=1.
